// File: rtl/serial_to_byte_sync_if.sv
// Serial line / aligned byte bundle for the receive deserializer.
// The slave side is the deserializer; the master side drives the line.
interface serial_to_byte_sync_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );
endinterface

// File: rtl/serial_to_byte_sync.sv
// Bit-serial deserializer with COM-based byte alignment and link lock.
// Optional stuck-line sync loss is enabled by defining SYNC_LOSS_EN.
module serial_to_byte_sync #(
    parameter logic [7:0] COM_CHAR   = 8'hBC,
    parameter int         SYNC_BC    = 4,
    parameter int         LOSS_LIMIT = 8
) (
    input  logic                  clk_32f,
    input  logic                  reset_L,
    serial_to_byte_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    generate
        if (SYNC_BC < 2 || SYNC_BC > 15) begin : g_bad_sync_bc
            $error("SYNC_BC out of range 2..15");
        end
        if (LOSS_LIMIT < 2 || LOSS_LIMIT > 255) begin : g_bad_loss
            $error("LOSS_LIMIT out of range 2..255");
        end
    endgenerate

    state_t     state, state_n;
    logic [7:0] sreg, sreg_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [3:0] bc_count, bc_n;
    logic [7:0] data_q, data_n;
    logic       valid_q, valid_n;

    logic [7:0] window;
    logic       is_com;
    logic       boundary;
    logic [3:0] bc_inc;

    assign window   = {sreg[6:0], bus.data_in};
    assign is_com   = (window == COM_CHAR);
    assign boundary = (bit_cnt == 3'd7);
    assign bc_inc   = (bc_count >= 4'(SYNC_BC)) ? bc_count
                                                : bc_count + 4'd1;

`ifdef SYNC_LOSS_EN
    logic [7:0] loss_cnt, loss_n;
    logic       stuck;

    assign stuck = (window == 8'h00) || (window == 8'hFF);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) loss_cnt <= '0;
        else          loss_cnt <= loss_n;
    end
`endif

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= INIT;
            sreg     <= '0;
            bit_cnt  <= '0;
            bc_count <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            bit_cnt  <= bit_cnt_n;
            bc_count <= bc_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
        end
    end

    always_comb begin
        state_n   = state;
        sreg_n    = window;
        bit_cnt_n = bit_cnt + 3'd1;
        bc_n      = bc_count;
        data_n    = data_q;
        valid_n   = valid_q;
`ifdef SYNC_LOSS_EN
        loss_n    = loss_cnt;
`endif
        unique case (state)
            INIT: begin
                // Bit-granular hunt; a match defines the next boundary
                bit_cnt_n = '0;
                data_n    = '0;
                valid_n   = 1'b0;
                if (is_com) begin
                    bc_n    = 4'd1;
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_com) begin
                        bc_n = bc_inc;
                        if (bc_inc == 4'(SYNC_BC)) state_n = ACTIVE;
                    end else begin
                        bc_n    = '0;
                        state_n = INIT;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_n  = window;
                    valid_n = !is_com;
`ifdef SYNC_LOSS_EN
                    if (stuck) begin
                        if (loss_cnt == 8'(LOSS_LIMIT - 1)) begin
                            state_n = INIT;
                            data_n  = '0;
                            valid_n = 1'b0;
                            bc_n    = '0;
                            loss_n  = '0;
                        end else begin
                            loss_n = loss_cnt + 8'd1;
                        end
                    end else begin
                        loss_n = '0;
                    end
`endif
                end
            end
            default: state_n = INIT;
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = (state == ACTIVE);

endmodule

// File: tb/tb_serial_to_byte_sync.sv
// Bench for serial_to_byte_sync: directed vectors plus random stream
// compared against a bit-history reference model.
module tb_serial_to_byte_sync;
    localparam logic [7:0] COM = 8'hBC;
    localparam int SBC = 4;
    localparam int LL  = 8;

    logic clk_32f = 1'b0;
    logic reset_L = 1'b0;

    serial_to_byte_sync_if bus();

    serial_to_byte_sync #(
        .COM_CHAR  (COM),
        .SYNC_BC   (SBC),
        .LOSS_LIMIT(LL)
    ) dut (
        .clk_32f(clk_32f),
        .reset_L(reset_L),
        .bus    (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: bit index arithmetic over the recent line history
    bit         mq[$];
    int         m_n, m_mode, m_lock, m_run, m_stuck;
    logic [7:0] m_data;
    bit         m_valid;

    function automatic void m_reset();
        mq.delete();
        m_n = 0; m_mode = 0; m_lock = 0; m_run = 0; m_stuck = 0;
        m_data = 8'h00; m_valid = 1'b0;
    endfunction

    function automatic logic [7:0] m_last8();
        logic [7:0] w = 8'h00;
        for (int i = 0; i < mq.size(); i++) w = {w[6:0], mq[i]};
        return w;
    endfunction

    function automatic void m_step(bit b);
        logic [7:0] w;
        bit bnd;
        mq.push_back(b);
        if (mq.size() > 8) void'(mq.pop_front());
        m_n++;
        w   = m_last8();
        bnd = (m_mode != 0) && ((m_n - m_lock) % 8 == 0);
        if (m_mode == 0) begin
            if (w == COM) begin
                m_mode = 1; m_lock = m_n; m_run = 1;
            end
        end else if (bnd) begin
            if (m_mode == 1) begin
                if (w == COM) begin
                    m_run++;
                    if (m_run >= SBC) m_mode = 2;
                end else begin
                    m_mode = 0; m_run = 0;
                end
            end else begin
                m_data  = w;
                m_valid = (w != COM);
`ifdef SYNC_LOSS_EN
                if (w == 8'h00 || w == 8'hFF) m_stuck++;
                else m_stuck = 0;
                if (m_stuck == LL) begin
                    m_mode = 0; m_run = 0; m_stuck = 0;
                    m_data = 8'h00; m_valid = 1'b0;
                end
`endif
            end
        end
    endfunction

    task automatic send_bit(bit b);
        @(negedge clk_32f);
        bus.data_in = b;
        @(posedge clk_32f);
        m_step(b);
        #1;
        chk("model_data", bus.data_out, m_data);
        chk("model_valid", 8'(bus.valid_out), 8'(m_valid));
        chk("model_active", 8'(bus.active), 8'(m_mode == 2));
    endtask

    task automatic send_byte(logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_valid", 8'(bus.valid_out), 8'h00);
        chk("rst_active", 8'(bus.active), 8'h00);
        m_reset();
        #1;
        reset_L = 1'b1;
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
        logic       vout;
    } vec_t;

    vec_t       tbl[3];
    logic [7:0] c;
    logic [7:0] pd;
    logic       pv;
    int         pick;

    initial begin
        tbl[0] = '{8'hA5, 8'hA5, 1'b1};
        tbl[1] = '{8'hBC, 8'hBC, 1'b0};
        tbl[2] = '{8'h3C, 8'h3C, 1'b1};
        c = COM;
        bus.data_in = 1'b0;
        m_reset();
        #1;
        chk("init_data", bus.data_out, 8'h00);
        chk("init_valid", 8'(bus.valid_out), 8'h00);
        chk("init_active", 8'(bus.active), 8'h00);
        #1;
        reset_L = 1'b1;

        // Reset mid-byte, then partial COM must not match
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_reset();
        for (int i = 4; i >= 0; i--) send_bit(c[i]);
        repeat (3) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(c[i]);
        chk("rstmid_pre", 8'(bus.active), 8'h00);
        send_bit(c[0]);
        chk("rstmid_lock", 8'(bus.active), 8'h01);
        do_reset();

        // Lock with 3-bit offset
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(c[i]);
        chk("off_pre", 8'(bus.active), 8'h00);
        send_bit(c[0]);
        chk("off_active", 8'(bus.active), 8'h01);
        chk("off_valid", 8'(bus.valid_out), 8'h00);

        // Data in ACTIVE, held 8 clocks each
        pd = 8'h00; pv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 7; i >= 0; i--) begin
                send_bit(tbl[k].din[i]);
                if (i > 0) begin
                    chk("tbl_hold_d", bus.data_out, pd);
                    chk("tbl_hold_v", 8'(bus.valid_out), 8'(pv));
                end else begin
                    chk("tbl_new_d", bus.data_out, tbl[k].dout);
                    chk("tbl_new_v", 8'(bus.valid_out), 8'(tbl[k].vout));
                end
            end
            pd = tbl[k].dout; pv = tbl[k].vout;
        end
        do_reset();

        // Broken sync
        send_byte(COM); send_byte(COM); send_byte(8'h55);
        chk("brk_drop", 8'(bus.active), 8'h00);
        repeat (3) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(c[i]);
        chk("brk_pre", 8'(bus.active), 8'h00);
        send_bit(c[0]);
        chk("brk_active", 8'(bus.active), 8'h01);

        // Stuck line after lock
        for (int k = 0; k < 7; k++) begin
            send_byte(8'h00);
            chk("stuck_d", bus.data_out, 8'h00);
            chk("stuck_v", 8'(bus.valid_out), 8'h01);
        end
        send_byte(8'h00);
`ifdef SYNC_LOSS_EN
        chk("loss_active", 8'(bus.active), 8'h00);
        chk("loss_valid", 8'(bus.valid_out), 8'h00);
`else
        chk("noloss_active", 8'(bus.active), 8'h01);
        chk("noloss_valid", 8'(bus.valid_out), 8'h01);
`endif
        do_reset();

        // Bit-shifted match inside 0x5E,0x00
        send_byte(8'h5E);
        send_bit(1'b0);
        chk("bs_notyet", 8'(bus.active), 8'h00);
        repeat (2) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(c[i]);
        chk("bs_pre", 8'(bus.active), 8'h00);
        send_bit(c[0]);
        chk("bs_active", 8'(bus.active), 8'h01);
        do_reset();

        // Random stream against the model
        for (int r = 0; r < 400; r++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 3) send_byte(COM);
            else if (pick == 4)
                repeat ($urandom_range(1, 10)) send_byte(8'h00);
            else if (pick == 5) send_byte(8'hFF);
            else if (pick == 6) send_bit(1'($urandom_range(0, 1)));
            else send_byte(8'($urandom));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
